// File: rtl/vdp_copper_v2.sv
// vdp_copper_v2 - raster-synchronised display-list coprocessor.
//
// Fetches 16-bit ops from copper RAM, waits on raster position and streams
// batched VDP register writes over a valid/ready handshake. Supports a
// call/return stack, halt, and a sticky fault flag.
//
// Ports:
//   i_clk, i_reset_n (sync, active low), i_enable (0 = hold in reset, keep fault)
//   i_raster_x / i_raster_y      current raster position
//   o_ram_read_address           copper RAM address (= pc), registered
//   i_ram_read_data              RAM word, valid the cycle after the address
//   o_reg_write_address/_data/_en, i_reg_write_ready   VDP write handshake
//   o_halted                     high in HALTED
//   o_fault                      sticky error flag, cleared only by i_reset_n
//
// state        | meaning
// S_ISSUE      | op address presented on the RAM port
// S_DECODE     | op word available, execute it
// S_DATA_ISSUE | data word address presented
// S_DATA_USE   | data word available, launch the register write
// S_WRITE_HS   | write held until accepted
// S_RASTER_WAIT| TARGET wait; pc+1 on hit
// S_BATCH_WAIT | auto Y-step wait between batches; resumes data without pc+1
// S_HALTED     | stopped until reset or disable

module vdp_copper_v2 #(
    parameter int PC_WIDTH       = 11,
    parameter int REG_ADDR_WIDTH = 6,
    parameter int X_WIDTH        = 11,
    parameter int Y_WIDTH        = 10,
    parameter int STACK_DEPTH    = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic [X_WIDTH-1:0]        i_raster_x,
    input  logic [Y_WIDTH-1:0]        i_raster_y,
    output logic [PC_WIDTH-1:0]       o_ram_read_address,
    input  logic [15:0]               i_ram_read_data,
    output logic [REG_ADDR_WIDTH-1:0] o_reg_write_address,
    output logic [15:0]               o_reg_write_data,
    output logic                      o_reg_write_en,
    input  logic                      i_reg_write_ready,
    output logic                      o_halted,
    output logic                      o_fault
);
    localparam int SP_WIDTH = $clog2(STACK_DEPTH + 1);
    localparam logic [PC_WIDTH-1:0] PC_ONE = 1;
    localparam logic [SP_WIDTH-1:0] SP_ONE = 1;
    localparam logic [Y_WIDTH-1:0]  Y_ONE  = 1;

    typedef enum logic [2:0] {
        S_ISSUE,
        S_DECODE,
        S_DATA_ISSUE,
        S_DATA_USE,
        S_WRITE_HS,
        S_RASTER_WAIT,
        S_BATCH_WAIT,
        S_HALTED
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]       r_pc, w_pc_nxt, w_pc_inc;
    logic [SP_WIDTH-1:0]       r_sp, w_sp_nxt;
    logic [PC_WIDTH-1:0]       r_stack [STACK_DEPTH];
    logic                      w_push;
    logic [PC_WIDTH-1:0]       w_pop_val;
    logic [X_WIDTH-1:0]        r_target_x, w_target_x_nxt;
    logic [Y_WIDTH-1:0]        r_target_y, w_target_y_nxt;
    logic                      r_cmp_ge, w_cmp_ge_nxt;
    logic [1:0]                r_mode, w_mode_nxt;
    logic                      r_auto_wait, w_auto_wait_nxt;
    logic [4:0]                r_batches_m1, w_batches_m1_nxt;
    logic [5:0]                r_base, w_base_nxt;
    logic [2:0]                r_word_cnt, w_word_cnt_nxt;
    logic [4:0]                r_batch_cnt, w_batch_cnt_nxt;
    logic [REG_ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [15:0]               r_wr_data, w_wr_data_nxt;
    logic                      r_wr_en, w_wr_en_nxt;
    logic                      r_fault, w_fault_nxt;
    logic                      w_hit;
    logic [2:0]                w_word_last;
    logic [PC_WIDTH-1:0]       w_flow_tgt;

    assign o_ram_read_address  = r_pc;
    assign o_reg_write_address = r_wr_addr;
    assign o_reg_write_data    = r_wr_data;
    assign o_reg_write_en      = r_wr_en;
    assign o_halted            = (r_state == S_HALTED);
    assign o_fault             = r_fault;

    assign w_pc_inc    = r_pc + PC_ONE;
    assign w_flow_tgt  = PC_WIDTH'(i_ram_read_data[11:0]);
    // Index of the last word in a batch: 0, 1, 3 or 7.
    assign w_word_last = 3'((4'd1 << r_mode) - 4'd1);

    // One cmp flag governs both axes of the target pair.
    always_comb begin
        if (r_cmp_ge) begin
            w_hit = (i_raster_y > r_target_y) ||
                    ((i_raster_y == r_target_y) && (i_raster_x >= r_target_x));
        end else begin
            w_hit = (i_raster_x == r_target_x) && (i_raster_y == r_target_y);
        end
    end

    always_comb begin
        w_pop_val = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SP_WIDTH'(i + 1)) begin
                w_pop_val = r_stack[i];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_sp_nxt         = r_sp;
        w_push           = 1'b0;
        w_target_x_nxt   = r_target_x;
        w_target_y_nxt   = r_target_y;
        w_cmp_ge_nxt     = r_cmp_ge;
        w_mode_nxt       = r_mode;
        w_auto_wait_nxt  = r_auto_wait;
        w_batches_m1_nxt = r_batches_m1;
        w_base_nxt       = r_base;
        w_word_cnt_nxt   = r_word_cnt;
        w_batch_cnt_nxt  = r_batch_cnt;
        w_wr_addr_nxt    = r_wr_addr;
        w_wr_data_nxt    = r_wr_data;
        w_wr_en_nxt      = r_wr_en;
        w_fault_nxt      = r_fault;

        case (r_state)
            S_ISSUE: w_state_nxt = S_DECODE;

            S_DECODE: begin
                case (i_ram_read_data[15:14])
                    2'd0: begin
                        w_cmp_ge_nxt = i_ram_read_data[13];
                        if (i_ram_read_data[11]) begin
                            w_target_y_nxt = Y_WIDTH'(i_ram_read_data[10:0]);
                        end else begin
                            w_target_x_nxt = X_WIDTH'(i_ram_read_data[10:0]);
                        end
                        if (i_ram_read_data[12]) begin
                            w_state_nxt = S_RASTER_WAIT;
                        end else begin
                            w_pc_nxt    = w_pc_inc;
                            w_state_nxt = S_ISSUE;
                        end
                    end
                    2'd1: begin
                        w_mode_nxt       = i_ram_read_data[13:12];
                        w_auto_wait_nxt  = i_ram_read_data[11];
                        w_batches_m1_nxt = i_ram_read_data[10:6];
                        w_base_nxt       = i_ram_read_data[5:0];
                        w_word_cnt_nxt   = '0;
                        w_batch_cnt_nxt  = '0;
                        w_pc_nxt         = w_pc_inc;
                        w_state_nxt      = S_DATA_ISSUE;
                    end
                    2'd2: begin
                        case (i_ram_read_data[13:12])
                            2'd0: begin
                                w_pc_nxt    = w_flow_tgt;
                                w_state_nxt = S_ISSUE;
                            end
                            2'd1: begin
                                // A full stack degrades the call to a plain jump.
                                if (r_sp == SP_WIDTH'(STACK_DEPTH)) begin
                                    w_fault_nxt = 1'b1;
                                end else begin
                                    w_push   = 1'b1;
                                    w_sp_nxt = r_sp + SP_ONE;
                                end
                                w_pc_nxt    = w_flow_tgt;
                                w_state_nxt = S_ISSUE;
                            end
                            2'd2: begin
                                if (r_sp == '0) begin
                                    w_fault_nxt = 1'b1;
                                    w_state_nxt = S_HALTED;
                                end else begin
                                    w_pc_nxt    = w_pop_val;
                                    w_sp_nxt    = r_sp - SP_ONE;
                                    w_state_nxt = S_ISSUE;
                                end
                            end
                            default: w_state_nxt = S_HALTED;
                        endcase
                    end
                    default: begin
                        w_fault_nxt = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_ISSUE;
                    end
                endcase
            end

            S_DATA_ISSUE: w_state_nxt = S_DATA_USE;

            S_DATA_USE: begin
                w_wr_data_nxt = i_ram_read_data;
                w_wr_addr_nxt = REG_ADDR_WIDTH'(r_base) + REG_ADDR_WIDTH'(r_word_cnt);
                w_wr_en_nxt   = 1'b1;
                w_state_nxt   = S_WRITE_HS;
            end

            S_WRITE_HS: begin
                if (i_reg_write_ready) begin
                    w_wr_en_nxt = 1'b0;
                    w_pc_nxt    = w_pc_inc;
                    if (r_word_cnt != w_word_last) begin
                        w_word_cnt_nxt = r_word_cnt + 3'd1;
                        w_state_nxt    = S_DATA_ISSUE;
                    end else if (r_batch_cnt == r_batches_m1) begin
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_word_cnt_nxt  = '0;
                        w_batch_cnt_nxt = r_batch_cnt + 5'd1;
                        if (r_auto_wait) begin
                            w_target_y_nxt = r_target_y + Y_ONE;
                            w_state_nxt    = S_BATCH_WAIT;
                        end else begin
                            w_state_nxt = S_DATA_ISSUE;
                        end
                    end
                end
            end

            S_RASTER_WAIT: begin
                if (w_hit) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_ISSUE;
                end
            end

            S_BATCH_WAIT: begin
                if (w_hit) begin
                    w_state_nxt = S_DATA_ISSUE;
                end
            end

            S_HALTED: w_state_nxt = S_HALTED;

            default: w_state_nxt = S_ISSUE;
        endcase
    end

    // Disable behaves as reset except that the fault flag survives it.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || !i_enable) begin
            r_state      <= S_ISSUE;
            r_pc         <= '0;
            r_sp         <= '0;
            r_target_x   <= '0;
            r_target_y   <= '0;
            r_cmp_ge     <= 1'b0;
            r_mode       <= '0;
            r_auto_wait  <= 1'b0;
            r_batches_m1 <= '0;
            r_base       <= '0;
            r_word_cnt   <= '0;
            r_batch_cnt  <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            if (!i_reset_n) begin
                r_fault <= 1'b0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_sp         <= w_sp_nxt;
            r_target_x   <= w_target_x_nxt;
            r_target_y   <= w_target_y_nxt;
            r_cmp_ge     <= w_cmp_ge_nxt;
            r_mode       <= w_mode_nxt;
            r_auto_wait  <= w_auto_wait_nxt;
            r_batches_m1 <= w_batches_m1_nxt;
            r_base       <= w_base_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_batch_cnt  <= w_batch_cnt_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_fault      <= w_fault_nxt;
        end
    end

    // Stack storage needs no reset: entries above sp are never read.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && i_enable && w_push) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (r_sp == SP_WIDTH'(i)) begin
                    r_stack[i] <= w_pc_inc;
                end
            end
        end
    end

endmodule

// File: doc/vdp_copper_v2.md
Name: vdp_copper_v2

Overview:
Second-generation raster-synchronised display-list coprocessor for the VDP. It fetches 16-bit ops from copper RAM and waits on raster position (equal or at/after). It then streams batched writes into VDP registers under a proper valid/ready handshake. New over gen 1: parametrised PC/register/raster widths, batch sizes up to 8, per-batch auto Y-step waits, call/return stack, halt, and sticky fault reporting.

Parameters:
PC_WIDTH, 11, copper RAM word-address width; legal range 4..12.
REG_ADDR_WIDTH, 6, VDP register address width; legal range 6..8; the 6-bit op field is zero-extended.
X_WIDTH, 11, raster_x width.
Y_WIDTH, 10, raster_y width.
STACK_DEPTH, 4, call stack entries; power of 2, 1..16.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
enable  in  1  0 = hold in reset state (same effect as reset_n=0, except fault is retained)
raster_x  in  X_WIDTH  current raster column
raster_y  in  Y_WIDTH  current raster line
ram_read_address  out  PC_WIDTH  registered copper RAM address (= pc)
ram_read_data  in  16  RAM word; valid the cycle after its address is presented
reg_write_address  out  REG_ADDR_WIDTH  VDP register address
reg_write_data  out  16  VDP register data
reg_write_en  out  1  write valid
reg_write_ready  in  1  VDP accepts the write this cycle
halted  out  1  high in HALTED state
fault  out  1  sticky error flag; cleared only by reset_n

Behaviour:
- Reset state (reset_n=0 or enable=0): pc=0, sp=0, target_x=0, target_y=0, state=ISSUE, reg_write_en=0, reg_write_address=0, reg_write_data=0, halted=0. reset_n=0 also sets fault=0. Any write in flight is abandoned; reg_write_en drops the next cycle.
- Op encoding, by ram_read_data[15:14]:
  - 0 TARGET: [13] cmp (0 = equal, 1 = greater-or-equal), [12] wait, [11] select (0 = x, 1 = y), [10:0] value, truncated to the target width.
  - 1 WRITE: [13:12] mode, batch size 1/2/4/8; [11] auto-wait; [10:6] batches-1; [5:0] base reg.
  - 2 FLOW: [13:12] sub (0 = JUMP, 1 = CALL, 2 = RETURN, 3 = HALT); [11:0] target, truncated to PC_WIDTH.
  - 3: reserved; executes as NOP and sets fault.
- Each RAM word costs one ISSUE cycle (address out) and one USE cycle (data consumed).
- FSM states: ISSUE, DECODE, DATA_ISSUE, DATA_USE, WRITE_HS, RASTER_WAIT, HALTED.
- ISSUE -> DECODE.
- DECODE:
  - TARGET: latch the value and cmp mode (one shared cmp flag for the x/y pair). If wait=1 go to RASTER_WAIT; otherwise pc+1, go to ISSUE.
  - WRITE: latch fields, word counter=0, batch counter=0, pc+1, go to DATA_ISSUE.
  - JUMP: pc=target, go to ISSUE.
  - CALL: if sp==STACK_DEPTH, set fault and behave as JUMP without push. Otherwise push pc+1, sp+1, pc=target.
  - RETURN: if sp==0, set fault and go to HALTED. Otherwise pop into pc, sp-1.
  - HALT: go to HALTED.
- Target hit:
  - cmp=0: raster_x==target_x && raster_y==target_y.
  - cmp=1: (raster_y>target_y) || (raster_y==target_y && raster_x>=target_x), unsigned.
- RASTER_WAIT: on hit, pc+1 and go to ISSUE; otherwise hold.
- DATA_ISSUE -> DATA_USE.
- DATA_USE:
  - reg_write_data = word; reg_write_address = base + (word counter mod batch size), computed in REG_ADDR_WIDTH with wrap; reg_write_en=1; go to WRITE_HS.
- WRITE_HS:
  - Hold address, data and en stable until reg_write_ready. In the accept cycle, drop en and pc+1.
  - Batch not done: word counter+1, go to DATA_ISSUE.
  - Batch done and batch counter == batches-1: go to ISSUE.
  - Batch done, more batches remaining, auto-wait=0: batch counter+1, go to DATA_ISSUE.
  - Batch done, more batches remaining, auto-wait=1: target_y = target_y+1 (wraps mod 2^Y_WIDTH), batch counter+1, go to a RASTER_WAIT variant. That variant returns to DATA_ISSUE without incrementing pc.
- Max total per op: 8 regs × 32 batches = 256 data words.
- Writes are never duplicated or dropped. Ready asserted before en is ignored.
- pc increments wrap mod 2^PC_WIDTH.
- HALTED: halted=1; stays there until reset_n=0 or enable=0.
- Simultaneous events: reset/enable take priority over every transition, including a handshake accept.

Test Plan:
- TARGET x=100 (no wait), then TARGET y=20 cmp=0 wait. Drive raster to (100,20) -> exactly one pc advance, in the cycle after the hit. (99,20) and (100,21) produce no advance.
- Same program with cmp=1, raster jumping from (0,19) to (150,25) -> release the cycle after the jump. An equal compare would never fire.
- WRITE mode=2, base 0x10, batches=2, 8 data words; reg_write_ready low 3 cycles per word -> addresses 0x10,0x11,0x12,0x13,0x10..0x13; data in RAM order; en held stable while ready is low; exactly 8 accepts.
- WRITE mode=0, auto-wait=1, target (5,40), 3 batches -> writes accepted at raster lines 40, 41 and 42 (x≥5 with cmp=1); target_y ends at 42.
- CALL nested STACK_DEPTH+1 deep -> fault=1, last call acts as jump. RETURN with sp==0 -> halted=1. Reserved op 3 -> fault=1 with pc+1.
- Pulse reset_n low mid-handshake (en=1, ready=0) -> en=0 on the next cycle, pc=0, fault cleared. enable=0 at the same point -> same, but fault retained.
